// File: rtl/pwm_stream_modulator_pkg.sv
// Shared defaults, mode encoding and width helpers for the PWM stream modulator.
package pwm_stream_modulator_pkg;

  localparam int PWM_STEPS_DEF     = 64;
  localparam int CLKS_PER_STEP_DEF = 4;

  typedef enum logic {
    MODE_LEFT   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Duty samples must represent 0..PWM_STEPS inclusive.
  function automatic int duty_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Step prescaler and symbol position counter; both held at zero while disabled.
module pwm_step_timer
  import pwm_stream_modulator_pkg::*;
#(
  parameter int PWM_STEPS     = PWM_STEPS_DEF,
  parameter int CLKS_PER_STEP = CLKS_PER_STEP_DEF,
  parameter int POS_W         = cnt_width(PWM_STEPS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  output logic             o_step_tick,
  output logic [POS_W-1:0] o_position,
  output logic             o_symbol_end
);

  localparam int STEP_W = cnt_width(CLKS_PER_STEP);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CLKS_PER_STEP - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(PWM_STEPS - 1);

  logic [STEP_W-1:0] r_step;
  logic [POS_W-1:0]  r_pos;
  logic              w_step_tick;

  assign w_step_tick = i_enable && (r_step == STEP_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step <= '0;
      r_pos  <= '0;
    end else if (!i_enable) begin
      r_step <= '0;
      r_pos  <= '0;
    end else begin
      r_step <= w_step_tick ? '0 : r_step + 1'b1;
      if (w_step_tick) begin
        r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
      end
    end
  end

  assign o_step_tick  = w_step_tick;
  assign o_position   = r_pos;
  // High throughout the last position; the boundary is its final step_tick.
  assign o_symbol_end = (r_pos == POS_LAST);

endmodule

// File: rtl/pwm_stream_modulator.sv
// Streams duty samples through a one-entry buffer into a left/centre-aligned PWM output.
module pwm_stream_modulator
  import pwm_stream_modulator_pkg::*;
#(
  parameter int PWM_STEPS     = PWM_STEPS_DEF,
  parameter int CLKS_PER_STEP = CLKS_PER_STEP_DEF,
  parameter int DUTY_W        = duty_width(PWM_STEPS),
  parameter bit UNDERRUN_HOLD = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_center_mode,
  input  logic [DUTY_W-1:0] i_duty_data,
  input  logic              i_duty_valid,
  output logic              o_duty_ready,
  input  logic              i_underrun_clr,
  output logic              o_pwm,
  output logic              o_sym_tick,
  output logic              o_underrun
);

  localparam int POS_W = cnt_width(PWM_STEPS);
  localparam int CMP_W = DUTY_W + 1;
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PWM_STEPS);
  localparam logic [CMP_W-1:0]  STEPS_C  = CMP_W'(PWM_STEPS);

  logic              r_started;
  logic [DUTY_W-1:0] r_buf;
  logic              r_buf_full;
  logic [DUTY_W-1:0] r_active_duty;
  pwm_mode_e         r_active_mode;
  logic              r_pwm;
  logic              r_sym_tick;
  logic              r_underrun;

  logic              w_step_tick;
  logic [POS_W-1:0]  w_position;
  logic              w_symbol_end;
  logic              w_start;
  logic              w_boundary;
  logic              w_xfer;
  logic [DUTY_W-1:0] w_buf_sat;
  logic [DUTY_W-1:0] w_load_duty;
  pwm_mode_e         w_next_mode;
  logic [DUTY_W-1:0] w_cmp_duty;
  pwm_mode_e         w_cmp_mode;
  logic [CMP_W-1:0]  w_d;
  logic [CMP_W-1:0]  w_p;
  logic [CMP_W-1:0]  w_lo;
  logic              w_pwm_next;

  pwm_step_timer #(
    .PWM_STEPS    (PWM_STEPS),
    .CLKS_PER_STEP(CLKS_PER_STEP),
    .POS_W        (POS_W)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (i_enable),
    .o_step_tick (w_step_tick),
    .o_position  (w_position),
    .o_symbol_end(w_symbol_end)
  );

  assign w_start     = i_enable && !r_started;
  assign w_boundary  = (w_step_tick && w_symbol_end) || w_start;
  assign w_xfer      = i_duty_valid && !r_buf_full;
  assign w_buf_sat   = (r_buf > DUTY_MAX) ? DUTY_MAX : r_buf;
  assign w_load_duty = r_buf_full ? w_buf_sat : (UNDERRUN_HOLD ? r_active_duty : '0);
  assign w_next_mode = pwm_mode_e'(i_center_mode);

  // On a start boundary position 0 is already live, so compare against the incoming symbol.
  assign w_cmp_duty = w_start ? w_load_duty : r_active_duty;
  assign w_cmp_mode = w_start ? w_next_mode : r_active_mode;
  assign w_d        = CMP_W'(w_cmp_duty);
  assign w_p        = CMP_W'(w_position);
  assign w_lo       = (STEPS_C - w_d) >> 1;

  always_comb begin
    w_pwm_next = 1'b0;
    if (w_cmp_mode == MODE_CENTER) begin
      w_pwm_next = (w_p >= w_lo) && (w_p < (w_lo + w_d));
    end else begin
      w_pwm_next = (w_p < w_d);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started     <= 1'b0;
      r_buf         <= '0;
      r_buf_full    <= 1'b0;
      r_active_duty <= '0;
      r_active_mode <= MODE_LEFT;
      r_pwm         <= 1'b0;
      r_sym_tick    <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_started  <= i_enable;
      r_pwm      <= i_enable && w_pwm_next;
      r_sym_tick <= w_boundary;

      if (w_boundary) begin
        r_active_duty <= w_load_duty;
        r_active_mode <= w_next_mode;
      end

      // A transfer can only coincide with a boundary when the buffer is empty: it refills it.
      if (w_xfer) begin
        r_buf      <= i_duty_data;
        r_buf_full <= 1'b1;
      end else if (w_boundary) begin
        r_buf_full <= 1'b0;
      end

      if (w_boundary && !r_buf_full) begin
        r_underrun <= 1'b1;
      end else if (i_underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign o_duty_ready = !r_buf_full;
  assign o_pwm        = r_pwm;
  assign o_sym_tick   = r_sym_tick;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_pwm_stream_modulator.sv
// Directed bench: two modulators (hold / no-hold underrun) with PWM_STEPS=8, CLKS_PER_STEP=2.
module tb_pwm_stream_modulator;

  localparam int STEPS = 8;
  localparam int CPS   = 2;
  localparam int DW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          center_mode = 1'b0;
  logic [DW-1:0] duty_data = '0;
  logic          duty_valid = 1'b0;
  logic          underrun_clr = 1'b0;

  logic ready_h1, pwm_h1, sym_h1, ur_h1;
  logic ready_h0, pwm_h0, sym_h0, ur_h0;

  int total = 0;
  int bad   = 0;

  logic [7:0]    mask1_tab [10];
  logic [7:0]    mask0_tab [10];
  bit            feed_tab  [10];
  logic [DW-1:0] duty_tab  [10];
  bit            mode_tab  [10];
  logic [DW-1:0] bp_list   [5];
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  pwm_stream_modulator #(
    .PWM_STEPS(STEPS), .CLKS_PER_STEP(CPS), .DUTY_W(DW), .UNDERRUN_HOLD(1'b1)
  ) dut_h1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_center_mode(center_mode),
    .i_duty_data(duty_data), .i_duty_valid(duty_valid), .o_duty_ready(ready_h1),
    .i_underrun_clr(underrun_clr), .o_pwm(pwm_h1), .o_sym_tick(sym_h1), .o_underrun(ur_h1)
  );

  pwm_stream_modulator #(
    .PWM_STEPS(STEPS), .CLKS_PER_STEP(CPS), .DUTY_W(DW), .UNDERRUN_HOLD(1'b0)
  ) dut_h0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_center_mode(center_mode),
    .i_duty_data(duty_data), .i_duty_valid(duty_valid), .o_duty_ready(ready_h0),
    .i_underrun_clr(underrun_clr), .o_pwm(pwm_h0), .o_sym_tick(sym_h0), .o_underrun(ur_h0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] left_mask(input logic [DW-1:0] d);
    logic [7:0] one;
    one = 8'd1;
    return (d >= 4'd8) ? 8'hFF : 8'((one << d) - 8'd1);
  endfunction

  initial begin
    int s, sp, pos, bp_idx;
    bit fed, bp_on, xfer_pending;
    logic [7:0] m1, m0;
    logic [DW-1:0] popped;

    // Symbols 0..9: 3L, 5L, 3C, 8C, 9L, 0L, 4L, (none), (none), 6C
    feed_tab  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    duty_tab  = '{4'd3, 4'd5, 4'd3, 4'd8, 4'd9, 4'd0, 4'd4, 4'd0, 4'd0, 4'd6};
    mode_tab  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    mask1_tab = '{8'h07, 8'h1F, 8'h1C, 8'hFF, 8'hFF, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h7E};
    mask0_tab = '{8'h07, 8'h1F, 8'h1C, 8'hFF, 8'hFF, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h7E};
    bp_list   = '{4'd2, 4'd7, 4'd1, 4'd5, 4'd6};
    fed = 1'b0; bp_on = 1'b0; xfer_pending = 1'b0; bp_idx = 0;
    m1 = '0; m0 = '0; popped = '0;

    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_pwm_h1", pwm_h1, 0);     chk("rst_pwm_h0", pwm_h0, 0);
    chk("rst_sym_h1", sym_h1, 0);     chk("rst_sym_h0", sym_h0, 0);
    chk("rst_ur_h1", ur_h1, 0);       chk("rst_ur_h0", ur_h0, 0);
    chk("rst_ready_h1", ready_h1, 1); chk("rst_ready_h0", ready_h0, 1);
    rst_n = 1'b1;
    tick();

    center_mode = mode_tab[0];
    duty_valid  = 1'b1;
    duty_data   = duty_tab[0];
    tick();
    duty_valid = 1'b0;
    chk("pre_ready_h1", ready_h1, 0);
    chk("pre_ready_h0", ready_h0, 0);
    enable = 1'b1;

    for (int k = 1; k <= 240; k++) begin
      tick();
      s   = (k - 1) / 16;
      sp  = (k - 1) % 16;
      pos = sp >> 1;

      if (sp == 0) begin
        if (s < 10) begin
          m1 = mask1_tab[s];
          m0 = mask0_tab[s];
        end else begin
          chk($sformatf("sb_avail_s%0d", s), sb.size() > 0, 1);
          if (sb.size() > 0) popped = sb.pop_front();
          m1 = left_mask(popped);
          m0 = m1;
        end
      end

      chk($sformatf("pwm_h1_k%0d", k), pwm_h1, m1[pos]);
      chk($sformatf("pwm_h0_k%0d", k), pwm_h0, m0[pos]);
      chk($sformatf("sym_h1_k%0d", k), sym_h1, (k == 1) || (k % 16 == 0));
      chk($sformatf("sym_h0_k%0d", k), sym_h0, (k == 1) || (k % 16 == 0));

      if (k == 1) begin
        chk("ready_after_start_h1", ready_h1, 1);
        chk("ready_after_start_h0", ready_h0, 1);
      end
      if (k == 1 || (k % 16 == 0 && k <= 96)) begin
        chk($sformatf("ur_h1_k%0d", k), ur_h1, 0);
        chk($sformatf("ur_h0_k%0d", k), ur_h0, 0);
      end
      if (k == 112 || k == 128 || k == 240) begin
        chk($sformatf("ur_set_h1_k%0d", k), ur_h1, 1);
        chk($sformatf("ur_set_h0_k%0d", k), ur_h0, 1);
      end
      if (k == 114) begin
        chk("ur_clr_h1", ur_h1, 0);
        chk("ur_clr_h0", ur_h0, 0);
      end
      if (fed && sp == 2) begin
        chk($sformatf("ready_drop_h1_k%0d", k), ready_h1, 0);
        chk($sformatf("ready_drop_h0_k%0d", k), ready_h0, 0);
        duty_valid = 1'b0;
        fed = 1'b0;
      end
      if (k >= 147 && k <= 223) begin
        chk($sformatf("bp_ready_h1_k%0d", k), ready_h1, (k % 16 == 0));
        chk($sformatf("bp_ready_h0_k%0d", k), ready_h0, (k % 16 == 0));
      end

      if (xfer_pending) begin
        sb.push_back(bp_list[bp_idx]);
        bp_idx++;
        xfer_pending = 1'b0;
      end
      if (bp_on) begin
        duty_valid = (bp_idx < 5);
        if (bp_idx < 5) duty_data = bp_list[bp_idx];
      end
      if (sp == 1 && s + 1 <= 9) begin
        center_mode = mode_tab[s + 1];
        if (feed_tab[s + 1]) begin
          duty_valid = 1'b1;
          duty_data  = duty_tab[s + 1];
          fed = 1'b1;
        end
      end
      if (k == 146) begin
        bp_on = 1'b1;
        bp_idx = 0;
        center_mode = 1'b0;
        duty_valid = 1'b1;
        duty_data = bp_list[0];
      end
      underrun_clr = (k == 113) || (k == 127);
      if (bp_on) xfer_pending = duty_valid && ready_h1;
    end

    chk("bp_accepted", bp_idx, 5);
    chk("bp_sb_drained", sb.size(), 0);

    duty_valid = 1'b1;
    duty_data  = 4'd7;
    tick();
    duty_valid = 1'b0;
    chk("hold_pwm_h1", pwm_h1, 1);
    chk("nohold_pwm_h0", pwm_h0, 0);
    chk("buf_full_h1", ready_h1, 0);
    chk("buf_full_h0", ready_h0, 0);

    #3 rst_n = 1'b0;
    #1;
    chk("arst_pwm_h1", pwm_h1, 0);     chk("arst_pwm_h0", pwm_h0, 0);
    chk("arst_sym_h1", sym_h1, 0);     chk("arst_sym_h0", sym_h0, 0);
    chk("arst_ur_h1", ur_h1, 0);       chk("arst_ur_h0", ur_h0, 0);
    chk("arst_ready_h1", ready_h1, 1); chk("arst_ready_h0", ready_h0, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ur_h1", ur_h1, 1);   chk("post_rst_ur_h0", ur_h0, 1);
    chk("post_rst_sym_h1", sym_h1, 1); chk("post_rst_sym_h0", sym_h0, 1);
    chk("post_rst_pwm_h1", pwm_h1, 0); chk("post_rst_pwm_h0", pwm_h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_stream_modulator.md
Name: pwm_stream_modulator

Overview:
- Parametrised PWM modulator that serialises a stream of duty-cycle samples into a single-bit PWM output. Each sample occupies one PWM symbol of PWM_STEPS steps.
- Replaces fixed, table-driven PWM generation. Duty values arrive from an upstream sample source (baseband/AM envelope) over a valid/ready handshake, and the output drives the RF switch/output pin.
- Adds left- or centre-aligned pulse placement, a one-entry sample buffer, underrun handling and symbol-boundary status.

Parameters:
- PWM_STEPS, 64, steps per PWM symbol; must be ≥2.
- CLKS_PER_STEP, 4, clk cycles per PWM step; must be ≥1.
- DUTY_W, $clog2(PWM_STEPS+1), width of duty samples.
- UNDERRUN_HOLD, 1, on underrun: 1 = repeat last duty, 0 = load duty 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset: asserted when 0, released synchronously to clk.
- enable  in  1  run modulator; 0 = idle.
- center_mode  in  1  0 = left-aligned pulse, 1 = centre-aligned pulse; sampled at symbol boundary only.
- duty_data  in  DUTY_W  duty sample: number of high steps per symbol.
- duty_valid  in  1  upstream sample valid.
- duty_ready  out  1  buffer can accept a sample.
- underrun_clr  in  1  clears sticky underrun flag.
- pwm  out  1  registered PWM output.
- sym_tick  out  1  one-cycle pulse on each symbol load.
- underrun  out  1  sticky: a symbol boundary found the buffer empty.

Behaviour:
- Reset values: pwm=0, sym_tick=0, underrun=0, duty_ready=1. All counters, buffer, active duty and active mode are 0; the started flag is 0.
- Step counter runs 0..CLKS_PER_STEP-1. step_tick is high in the cycle where it equals CLKS_PER_STEP-1, then the counter wraps to 0.
- Position counter runs 0..PWM_STEPS-1 and advances on step_tick, wrapping to 0.
- A boundary occurs when:
  - step_tick is high and position is PWM_STEPS-1, or
  - it is the first cycle with enable=1 while started=0; started is then set.
- enable=0:
  - step and position counters are forced to 0, started is cleared, and pwm is driven to 0 on the next clk.
  - The buffer keeps accepting samples.
- Handshake:
  - duty_ready = !buf_full, registered; it is not combinationally dependent on duty_valid.
  - A transfer occurs when duty_valid && duty_ready. Data is latched into the buffer and buf_full is set.
  - duty_data is don't-care when duty_valid=0.
- At a boundary with buf_full=1:
  - active_duty ← min(buf, PWM_STEPS), i.e. saturated.
  - buf_full ← 0 and active_mode ← center_mode.
  - sym_tick pulses in the same cycle.
- At a boundary with buf_full=0:
  - active_duty ← UNDERRUN_HOLD ? active_duty : 0, and active_mode ← center_mode.
  - underrun ← 1 and sym_tick pulses.
- A transfer and a boundary in the same cycle are possible only when buffer is empty. This is treated as underrun; the new sample is buffered for the next boundary, with no bypass.
- underrun_clr clears the flag. If underrun_clr and a new underrun occur in the same cycle, set wins.
- pwm is registered from the current position p and the active duty d; it changes one clk after a position change.
  - Left mode: pwm = (p < d).
  - Centre mode: with lo = (PWM_STEPS - d) >> 1, pwm = (p ≥ lo) && (p < lo + d). An odd remainder places the extra low step at the symbol end.
- Duty edge cases: d=0 gives constant low for the symbol; d ≥ PWM_STEPS gives constant high for the symbol.
- Latency: a sample accepted while the buffer is empty becomes active at the next boundary. The first pwm edge of that symbol appears 1 clk after the boundary.
- Reset assertion mid-symbol immediately forces all outputs to reset values and discards buffered data.

Decomposition:
- Shared package/defines file (project defines):
  - PWM_STEPS and CLKS_PER_STEP defaults.
  - DUTY_W derivation.
  - Mode encoding constants: MODE_LEFT=0, MODE_CENTER=1.
- One sub-module: pwm_step_timer, containing the step counter and position counter with enable/clear. It outputs step_tick, position and symbol_end.
- Buffer, boundary logic and comparator stay in the top module.

Test Plan:
- Left-aligned duty:
  - Stimulus: PWM_STEPS=8, CLKS_PER_STEP=2, left mode, samples 3 then 5 back-to-back.
  - Required: symbol 1 high for 6 clks then low for 10; symbol 2 high for 10 then low for 6; sym_tick spaced 16 clks apart.
- Centre-aligned odd remainder:
  - Stimulus: PWM_STEPS=8, centre mode, duty 3.
  - Required: lo=2, so pwm is high at positions 2..4 and low at 0,1,5,6,7.
  - Stimulus: duty 8. Required: constant high.
- Saturation and zero:
  - Stimulus: duty 9 with PWM_STEPS=8.
  - Required: high for the entire symbol.
  - Stimulus: duty 0. Required: pwm stays 0 and sym_tick still pulses.
- Underrun:
  - Stimulus: stop supplying samples after duty 4; run with UNDERRUN_HOLD=1, then again with 0.
  - Required: underrun=1 at the next boundary.
  - Required: HOLD=1 repeats duty 4; HOLD=0 gives pwm=0.
  - Required: underrun_clr clears the flag; set wins on a coincident clear.
- Backpressure:
  - Stimulus: hold duty_valid=1 continuously.
  - Required: duty_ready drops after each accept and reasserts 1 clk after each boundary.
  - Required: exactly one sample is consumed per symbol and none are lost or duplicated, checked by scoreboard.
- Async reset:
  - Stimulus: assert rst=0 mid-symbol, asynchronously to clk.
  - Required: pwm, sym_tick and underrun go to 0 without waiting for a clk edge, and duty_ready goes to 1.
  - Required: after release, the first boundary with enable=1 shows underrun (buffer discarded).
